argmax_layer: RTL

ARGMAX_LAYER -- requirements
Module: argmax_layer

---
 rtl/argmax_layer_pkg.sv | 21 ++
 rtl/fixed_point_greater.sv | 17 +
 rtl/argmax_layer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/argmax_layer_pkg.sv
// Shared fixed-point score type and argmax FSM state encoding.
// Imported by argmax_layer and fixed_point_greater (and reusable by other layers).
package argmax_layer_pkg;

    localparam int INTEGRAL_WIDTH = 8;
    localparam int FRACTION_WIDTH = 8;
    localparam int FP_W           = INTEGRAL_WIDTH + FRACTION_WIDTH;

    // Two's complement value spread over {integral, fraction}; compare as one signed word.
    typedef struct packed {
        logic [INTEGRAL_WIDTH-1:0] integral;
        logic [FRACTION_WIDTH-1:0] fraction;
    } fixed_point;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_e;

endpackage

// File: rtl/fixed_point_greater.sv
// Combinational strict signed compare of two fixed_point scores: a_gt_b = (a > b).
module fixed_point_greater
    import argmax_layer_pkg::*;
(
    input  fixed_point a,
    input  fixed_point b,
    output logic       a_gt_b
);

    logic signed [FP_W-1:0] a_s;
    logic signed [FP_W-1:0] b_s;

    assign a_s    = a;
    assign b_s    = b;
    assign a_gt_b = (a_s > b_s);

endmodule

// File: rtl/argmax_layer.sv
// Sequential argmax over NUM_INPUTS fixed_point scores: snapshot, scan one per cycle, pulse result.
// Optional max_value output enabled by defining macro ARGMAX_MAX_VALUE_EN.
module argmax_layer
    import argmax_layer_pkg::*;
#(
    parameter int NUM_INPUTS = 10,
    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    localparam int CNT_W = $clog2(NUM_INPUTS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inputs_ready,
    input  fixed_point       inputs [NUM_INPUTS],
    output logic             outputs_ready,
    output logic [IDX_W-1:0] index,
    output logic             busy
`ifdef ARGMAX_MAX_VALUE_EN
    ,
    output fixed_point       max_value
`endif
);

    if (NUM_INPUTS < 1 || NUM_INPUTS > 1024) begin : g_bad_num_inputs
        $fatal(1, "argmax_layer: NUM_INPUTS must be within 1..1024");
    end

    argmax_state_e    state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    fixed_point       best_q, best_d;
    logic [IDX_W-1:0] best_index_q, best_index_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             outputs_ready_q, outputs_ready_d;
    fixed_point       snapshot_q [NUM_INPUTS];
    fixed_point       snapshot_d [NUM_INPUTS];
`ifdef ARGMAX_MAX_VALUE_EN
    fixed_point       max_value_q, max_value_d;
`endif

    logic [IDX_W-1:0] cand_idx;
    logic             cand_gt;

    assign cand_idx = count_q[IDX_W-1:0];

    fixed_point_greater u_greater (
        .a      (snapshot_q[cand_idx]),
        .b      (best_q),
        .a_gt_b (cand_gt)
    );

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        best_d          = best_q;
        best_index_d    = best_index_q;
        index_d         = index_q;
        outputs_ready_d = 1'b0;
        snapshot_d      = snapshot_q;
`ifdef ARGMAX_MAX_VALUE_EN
        max_value_d     = max_value_q;
`endif
        case (state_q)
            IDLE: begin
                if (inputs_ready) begin
                    snapshot_d   = inputs;
                    best_d       = inputs[0];
                    best_index_d = '0;
                    count_d      = CNT_W'(1);
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                if (count_q == CNT_W'(NUM_INPUTS)) begin
                    index_d         = best_index_q;
                    outputs_ready_d = 1'b1;
                    state_d         = DONE;
`ifdef ARGMAX_MAX_VALUE_EN
                    max_value_d     = best_q;
`endif
                end else begin
                    // Strict greater-than keeps the lowest index on ties.
                    if (cand_gt) begin
                        best_d       = snapshot_q[cand_idx];
                        best_index_d = cand_idx;
                    end
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the snapshot array is
    // cleared on reset as well, so an aborted capture can never surface in a later result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            count_q         <= '0;
            best_q          <= '0;
            best_index_q    <= '0;
            index_q         <= '0;
            outputs_ready_q <= 1'b0;
            snapshot_q      <= '{default: '0};
`ifdef ARGMAX_MAX_VALUE_EN
            max_value_q     <= '0;
`endif
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            best_q          <= best_d;
            best_index_q    <= best_index_d;
            index_q         <= index_d;
            outputs_ready_q <= outputs_ready_d;
            snapshot_q      <= snapshot_d;
`ifdef ARGMAX_MAX_VALUE_EN
            max_value_q     <= max_value_d;
`endif
        end
    end

    assign outputs_ready = outputs_ready_q;
    assign index         = index_q;
    assign busy          = (state_q != IDLE);
`ifdef ARGMAX_MAX_VALUE_EN
    assign max_value     = max_value_q;
`endif

endmodule
